// File: rtl/tl_rx_vc_hdr_multi_buffer.sv
// Per-virtual-channel TLP header buffer: NUM_CH independent circular FIFOs with
// write/commit staging, single-cycle registered pop, credit release and sticky error flags.
module tl_rx_vc_hdr_multi_buffer #(
  parameter int unsigned DW             = 32,
  parameter int unsigned HDR_FIELD_SIZE = 8,
  parameter int unsigned BUFFER_WIDTH   = 4 * DW,
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned CH_W           = 2
) (
  input  logic                             i_clk,
  input  logic                             i_n_rst,
  input  logic                             i_w_en,
  input  logic                             i_w_commit,
  input  logic [CH_W-1:0]                  i_w_ch,
  input  logic [BUFFER_WIDTH-1:0]          i_w_tlp_hdr,
  input  logic                             i_r_req,
  input  logic [CH_W-1:0]                  i_r_ch,
  output logic                             o_r_valid,
  output logic [BUFFER_WIDTH-1:0]          o_r_tlp_hdr,
  output logic [CH_W-1:0]                  o_r_ch,
  output logic [NUM_CH*HDR_FIELD_SIZE-1:0] o_w_ptr,
  output logic [NUM_CH*HDR_FIELD_SIZE-1:0] o_r_ptr,
  output logic [NUM_CH*HDR_FIELD_SIZE-1:0] o_count,
  output logic [NUM_CH-1:0]                o_full,
  output logic [NUM_CH-1:0]                o_empty,
  output logic [NUM_CH-1:0]                o_hdr_cred_rel,
  output logic [NUM_CH-1:0]                o_ovf_err,
  output logic [NUM_CH-1:0]                o_udf_err,
  input  logic                             i_clr_err
);

  localparam int unsigned AW    = HDR_FIELD_SIZE - 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [HDR_FIELD_SIZE-1:0] w_ptr_q [NUM_CH];
  logic [HDR_FIELD_SIZE-1:0] r_ptr_q [NUM_CH];
  logic [BUFFER_WIDTH-1:0]   mem_q   [NUM_CH][DEPTH];

  logic [NUM_CH-1:0]       full, empty, w_sel, r_sel;
  logic [NUM_CH-1:0]       wr_ok, cm_ok, rd_ok, ovf_set, udf_set;
  logic [BUFFER_WIDTH-1:0] rd_data;

  // Out-of-range channel selects match no k, so they fall through as silent no-ops.
  always_comb begin
    full    = '0;
    empty   = '0;
    w_sel   = '0;
    r_sel   = '0;
    wr_ok   = '0;
    cm_ok   = '0;
    rd_ok   = '0;
    ovf_set = '0;
    udf_set = '0;
    rd_data = '0;
    o_w_ptr = '0;
    o_r_ptr = '0;
    o_count = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_sel[k]   = (32'(i_w_ch) == k);
      r_sel[k]   = (32'(i_r_ch) == k);
      empty[k]   = (w_ptr_q[k] == r_ptr_q[k]);
      full[k]    = (w_ptr_q[k][AW] != r_ptr_q[k][AW]) &&
                   (w_ptr_q[k][AW-1:0] == r_ptr_q[k][AW-1:0]);
      wr_ok[k]   = w_sel[k] & i_w_en & ~full[k];
      cm_ok[k]   = w_sel[k] & i_w_commit & ~full[k];
      ovf_set[k] = w_sel[k] & (i_w_en | i_w_commit) & full[k];
      rd_ok[k]   = r_sel[k] & i_r_req & ~empty[k];
      udf_set[k] = r_sel[k] & i_r_req & empty[k];
      if (rd_ok[k]) rd_data = mem_q[k][r_ptr_q[k][AW-1:0]];
      o_w_ptr[k*HDR_FIELD_SIZE +: HDR_FIELD_SIZE] = w_ptr_q[k];
      o_r_ptr[k*HDR_FIELD_SIZE +: HDR_FIELD_SIZE] = r_ptr_q[k];
      o_count[k*HDR_FIELD_SIZE +: HDR_FIELD_SIZE] = w_ptr_q[k] - r_ptr_q[k];
    end
    o_full  = full;
    o_empty = empty;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (wr_ok[k]) mem_q[k][w_ptr_q[k][AW-1:0]] <= i_w_tlp_hdr;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        w_ptr_q[k] <= '0;
        r_ptr_q[k] <= '0;
      end
      o_r_valid      <= 1'b0;
      o_r_tlp_hdr    <= '0;
      o_r_ch         <= '0;
      o_hdr_cred_rel <= '0;
      o_ovf_err      <= '0;
      o_udf_err      <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (cm_ok[k]) w_ptr_q[k] <= w_ptr_q[k] + HDR_FIELD_SIZE'(1);
        if (rd_ok[k]) r_ptr_q[k] <= r_ptr_q[k] + HDR_FIELD_SIZE'(1);
      end
      o_r_valid      <= |rd_ok;
      o_hdr_cred_rel <= rd_ok;
      if (|rd_ok) begin
        o_r_tlp_hdr <= rd_data;
        o_r_ch      <= i_r_ch;
      end
      // A new error event in the clear cycle keeps its bit set.
      o_ovf_err <= (o_ovf_err & ~{NUM_CH{i_clr_err}}) | ovf_set;
      o_udf_err <= (o_udf_err & ~{NUM_CH{i_clr_err}}) | udf_set;
    end
  end

endmodule

// File: tb/tb_tl_rx_vc_hdr_multi_buffer.sv
// Scoreboard bench for tl_rx_vc_hdr_multi_buffer: directed stimulus pushes expected pops,
// a negedge monitor compares every returned header.
module tb_tl_rx_vc_hdr_multi_buffer;
  localparam int H  = 8;
  localparam int BW = 128;
  localparam int NC = 3;
  localparam int CW = 2;

  logic            i_clk = 1'b0;
  logic            i_n_rst = 1'b0;
  logic            i_w_en = 1'b0, i_w_commit = 1'b0, i_r_req = 1'b0, i_clr_err = 1'b0;
  logic [CW-1:0]   i_w_ch = '0, i_r_ch = '0;
  logic [BW-1:0]   i_w_tlp_hdr = '0;
  logic            o_r_valid;
  logic [BW-1:0]   o_r_tlp_hdr;
  logic [CW-1:0]   o_r_ch;
  logic [NC*H-1:0] o_w_ptr, o_r_ptr, o_count;
  logic [NC-1:0]   o_full, o_empty, o_hdr_cred_rel, o_ovf_err, o_udf_err;

  tl_rx_vc_hdr_multi_buffer #(
    .DW(32), .HDR_FIELD_SIZE(H), .BUFFER_WIDTH(BW), .NUM_CH(NC), .CH_W(CW)
  ) dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst), .i_w_en(i_w_en), .i_w_commit(i_w_commit),
    .i_w_ch(i_w_ch), .i_w_tlp_hdr(i_w_tlp_hdr), .i_r_req(i_r_req), .i_r_ch(i_r_ch),
    .o_r_valid(o_r_valid), .o_r_tlp_hdr(o_r_tlp_hdr), .o_r_ch(o_r_ch),
    .o_w_ptr(o_w_ptr), .o_r_ptr(o_r_ptr), .o_count(o_count), .o_full(o_full),
    .o_empty(o_empty), .o_hdr_cred_rel(o_hdr_cred_rel), .o_ovf_err(o_ovf_err),
    .o_udf_err(o_udf_err), .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [BW-1:0] hdr;
    logic [CW-1:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [H-1:0] fld(input logic [NC*H-1:0] v, input int ch);
    return v[ch*H +: H];
  endfunction

  function automatic logic [BW-1:0] mk(input int ch, input int i);
    return {32'(ch), 32'(i), ~32'(i), 32'hC0DE_F00D};
  endfunction

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (i_n_rst) begin
      if (o_r_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_read: got hdr %h ch %0d, expected no read", o_r_tlp_hdr,
                   o_r_ch);
        end else begin
          e = exp_q.pop_front();
          check("rd_hdr", o_r_tlp_hdr, e.hdr);
          check("rd_ch", BW'(o_r_ch), BW'(e.ch));
          check("cred_rel", BW'(o_hdr_cred_rel), BW'(NC'(1) << e.ch));
        end
      end else begin
        check("cred_idle", BW'(o_hdr_cred_rel), '0);
      end
    end
  end

  task automatic cyc(input logic we, input logic wc, input logic [CW-1:0] wch,
                     input logic [BW-1:0] hdr, input logic rr, input logic [CW-1:0] rch,
                     input logic clr);
    i_w_en = we; i_w_commit = wc; i_w_ch = wch; i_w_tlp_hdr = hdr;
    i_r_req = rr; i_r_ch = rch; i_clr_err = clr;
    @(posedge i_clk);
    #1;
    i_w_en = 0; i_w_commit = 0; i_w_ch = '0; i_w_tlp_hdr = '0;
    i_r_req = 0; i_r_ch = '0; i_clr_err = 0;
  endtask

  task automatic wr(input logic [CW-1:0] ch, input logic [BW-1:0] hdr);
    cyc(1, 1, ch, hdr, 0, '0, 0);
  endtask

  task automatic rd(input logic [CW-1:0] ch, input logic [BW-1:0] exp_hdr);
    exp_q.push_back('{hdr: exp_hdr, ch: ch});
    cyc(0, 0, '0, '0, 1, ch, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, BW'(o_empty), BW'(3'b111));
    check({tag, "_full"}, BW'(o_full), '0);
    check({tag, "_count"}, BW'(o_count), '0);
    check({tag, "_wptr"}, BW'(o_w_ptr), '0);
    check({tag, "_rptr"}, BW'(o_r_ptr), '0);
    check({tag, "_valid"}, BW'(o_r_valid), '0);
    check({tag, "_hdr"}, o_r_tlp_hdr, '0);
    check({tag, "_rch"}, BW'(o_r_ch), '0);
    check({tag, "_cred"}, BW'(o_hdr_cred_rel), '0);
    check({tag, "_ovf"}, BW'(o_ovf_err), '0);
    check({tag, "_udf"}, BW'(o_udf_err), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*H-1:0] wsave, rsave;
    #2;
    check_reset_state("rst");
    @(posedge i_clk);
    #1 i_n_rst = 1'b1;

    // Single header round-trip, then overwrite-before-commit
    wr(0, mk(0, 1));
    rd(0, mk(0, 1));
    check("rt_empty0", BW'(o_empty[0]), 1);
    check("rt_count0", BW'(fld(o_count, 0)), 0);
    cyc(1, 0, 0, mk(0, 2), 0, '0, 0);
    cyc(1, 0, 0, mk(0, 3), 0, '0, 0);
    check("stage_count0", BW'(fld(o_count, 0)), 0);
    cyc(0, 1, 0, '0, 0, '0, 0);
    rd(0, mk(0, 3));

    // Fill ch2 to full, overflow, drain
    for (int i = 0; i < 128; i++) wr(2, mk(2, i));
    check("fill_full2", BW'(o_full[2]), 1);
    check("fill_count2", BW'(fld(o_count, 2)), 8'h80);
    check("fill_wptr2", BW'(fld(o_w_ptr, 2)), 8'h80);
    wr(2, mk(2, 999));
    check("ovf_wptr2", BW'(fld(o_w_ptr, 2)), 8'h80);
    check("ovf_err", BW'(o_ovf_err), BW'(3'b100));
    for (int i = 0; i < 128; i++) rd(2, mk(2, i));
    check("drain_empty2", BW'(o_empty[2]), 1);
    check("drain_rptr2", BW'(fld(o_r_ptr, 2)), 8'h80);
    cyc(0, 0, '0, '0, 0, '0, 1);
    check("ovf_clr", BW'(o_ovf_err), '0);

    // Fill and drain ch1 twice so the pointers wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) wr(1, mk(1, r * 128 + i));
      check("wrap_count1_full", BW'(fld(o_count, 1)), 8'h80);
      check("wrap_full1", BW'(o_full[1]), 1);
      for (int i = 0; i < 128; i++) rd(1, mk(1, r * 128 + i));
      check("wrap_count1_empty", BW'(fld(o_count, 1)), 0);
    end
    check("wrap_wptr1", BW'(fld(o_w_ptr, 1)), 0);
    check("wrap_rptr1", BW'(fld(o_r_ptr, 1)), 0);

    // Underflow on empty ch1, clear, and error-wins-over-clear
    cyc(0, 0, '0, '0, 1, 1, 0);
    check("udf_valid", BW'(o_r_valid), 0);
    check("udf_err", BW'(o_udf_err), BW'(3'b010));
    check("udf_hold_hdr", o_r_tlp_hdr, mk(1, 255));
    cyc(0, 0, '0, '0, 1, 0, 1);
    check("clr_vs_err", BW'(o_udf_err), BW'(3'b001));
    cyc(0, 0, '0, '0, 0, '0, 1);
    check("udf_clr", BW'(o_udf_err), '0);

    // Same-cycle commit+read on one channel, and on different channels
    for (int i = 0; i < 5; i++) wr(0, mk(0, 10 + i));
    check("cnt5_pre", BW'(fld(o_count, 0)), 5);
    exp_q.push_back('{hdr: mk(0, 10), ch: 2'd0});
    cyc(1, 1, 0, mk(0, 15), 1, 0, 0);
    check("cnt5_post", BW'(fld(o_count, 0)), 5);
    wr(2, mk(2, 500));
    exp_q.push_back('{hdr: mk(2, 500), ch: 2'd2});
    cyc(1, 1, 1, mk(1, 20), 1, 2, 0);
    check("xch_count1", BW'(fld(o_count, 1)), 1);
    check("xch_count2", BW'(fld(o_count, 2)), 0);
    check("xch_empty2", BW'(o_empty[2]), 1);

    // Out-of-range channel is a silent no-op
    wsave = o_w_ptr;
    rsave = o_r_ptr;
    cyc(1, 1, 3, mk(3, 0), 1, 3, 0);
    check("inv_wptr", BW'(o_w_ptr), BW'(wsave));
    check("inv_rptr", BW'(o_r_ptr), BW'(rsave));
    check("inv_ovf", BW'(o_ovf_err), '0);
    check("inv_udf", BW'(o_udf_err), '0);

    // Asynchronous reset mid-stream with nonzero counts
    check("pre_rst_count0", BW'(fld(o_count, 0)), 5);
    @(posedge i_clk);
    #3 i_n_rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge i_clk);
    #1 i_n_rst = 1'b1;
    wr(1, mk(1, 77));
    rd(1, mk(1, 77));
    cyc(0, 0, '0, '0, 0, '0, 0);
    cyc(0, 0, '0, '0, 0, '0, 0);
    check("post_rst_empty1", BW'(o_empty[1]), 1);
    check("sb_drained", BW'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
